// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state type and default geometry/latency for main_memory
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_WAIT_CYCLES = 4;

    // A latency of zero cycles is meaningless for this FSM, so clamp to one.
    function automatic int eff_wait(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// rtl/mem_wait_ctr.sv - loadable down-counter pacing the main_memory access latency
module mem_wait_ctr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    // done marks the edge on which the access is performed.
    assign done = (count == W'(1));

endmodule

// File: rtl/main_memory.sv
// rtl/main_memory.sv - fixed-latency word memory for the cache controller; MEM_ADDR_CHECK_EN enables range errors
module main_memory
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int MEM_DEPTH   = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              MBusy,
    output logic              MErr
);

    localparam int WAIT_EFF = eff_wait(WAIT_CYCLES);
    localparam int CTR_W    = $clog2(WAIT_EFF + 1);

    mem_state_e        state;
    mem_state_e        state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic              ctr_load;
    logic              ctr_done;
    logic              access_fire;
    logic              addr_ok;

    logic [DATA_W-1:0] mem [2**ADDR_W];

`ifdef MEM_ADDR_CHECK_EN
    assign addr_ok = (32'(addr_q) < 32'(MEM_DEPTH));
`else
    logic unused_depth;
    assign addr_ok      = 1'b1;
    assign unused_depth = (32'(addr_q) < 32'(MEM_DEPTH));
`endif

    assign ctr_load    = (state == IDLE) && MStrobe;
    assign access_fire = (state == ACCESS) && ctr_done;

    mem_wait_ctr #(
        .W (CTR_W)
    ) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (CTR_W'(WAIT_EFF)),
        .done     (ctr_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (MStrobe) state_nxt = ACCESS;
            ACCESS:  if (ctr_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            MDataOut <= '0;
        end else begin
            state <= state_nxt;
            if (ctr_load) begin
                addr_q <= MAddr;
                rw_q   <= MRW;
                data_q <= MDataIn;
            end
            if (access_fire) begin
                err_q <= !addr_ok;
                if (!rw_q) begin
                    MDataOut <= addr_ok ? mem[addr_q] : '0;
                end
            end
        end
    end

    // The array carries no reset; an aborted access never reaches ACCESS's final edge.
    always_ff @(posedge clk) begin
        if (access_fire && rw_q && addr_ok) begin
            mem[addr_q] <= data_q;
        end
    end

    assign MBusy  = (state != IDLE);
    assign MReady = (state == DONE);
    assign MErr   = MReady && err_q;

endmodule

// File: tb/tb_main_memory.sv
// tb/tb_main_memory.sv - directed self-checking bench for main_memory (default and WAIT_CYCLES=0 instances)
module tb_main_memory;

    logic        clk;
    logic        reset;
    logic        strobe;
    logic        strobe0;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ready;
    logic        busy;
    logic        err;
    logic [31:0] dout0;
    logic        ready0;
    logic        busy0;
    logic        err0;

    int checks;
    int errors;

    main_memory dut (
        .clk      (clk),
        .reset    (reset),
        .MStrobe  (strobe),
        .MRW      (rw),
        .MAddr    (addr),
        .MDataIn  (din),
        .MDataOut (dout),
        .MReady   (ready),
        .MBusy    (busy),
        .MErr     (err)
    );

    main_memory #(.WAIT_CYCLES(0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .MStrobe  (strobe0),
        .MRW      (rw),
        .MAddr    (addr),
        .MDataIn  (din),
        .MDataOut (dout0),
        .MReady   (ready0),
        .MBusy    (busy0),
        .MErr     (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one access and returns edges-to-MReady (counted from the accepting edge).
    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] q, output logic e);
        rw = w; addr = a; din = d; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        lat = 0;
        while (!ready && lat < 20) begin
            tick();
            lat++;
        end
        q = dout;
        e = err;
        tick();
    endtask

    int          lat;
    logic [31:0] q;
    logic        e;
    int          pulses;

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; strobe = 1'b0; strobe0 = 1'b0;
        rw = 1'b0; addr = '0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_dout", dout, 0);
        reset = 1'b1;
        tick();

        // Write 0x10 with explicit cycle-by-cycle checks
        rw = 1'b1; addr = 8'h10; din = 32'hDEADBEEF; strobe = 1'b1;
        tick();
        check("wr_busy_e0", busy, 1);
        check("wr_ready_e0", ready, 0);
        strobe = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("wr_ready_early", ready, 0);
        end
        tick();
        check("wr_ready_e4", ready, 1);
        check("wr_busy_e4", busy, 1);
        check("wr_dout_hold", dout, 0);
        tick();
        check("wr_ready_e5", ready, 0);
        check("wr_busy_e5", busy, 0);

        access(1'b0, 8'h10, 32'h0, lat, q, e);
        check("rd10_lat", lat, 4);
        check("rd10_data", q, 32'hDEADBEEF);
        check("rd10_err", e, 0);

        // Requests during an access are ignored, latched values are kept
        access(1'b1, 8'h20, 32'hAAAA0000, lat, q, e);
        rw = 1'b1; addr = 8'h30; din = 32'h11112222; strobe = 1'b1;
        tick();
        addr = 8'h20; din = 32'h55555555;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) strobe = 1'b0;
            tick();
            if (ready) pulses++;
        end
        check("busy_ign_pulses", pulses, 1);
        access(1'b0, 8'h30, 32'h0, lat, q, e);
        check("busy_ign_rd30", q, 32'h11112222);
        access(1'b0, 8'h20, 32'h0, lat, q, e);
        check("busy_ign_rd20", q, 32'hAAAA0000);

        // Reset during ACCESS aborts the write
        access(1'b1, 8'h11, 32'h0, lat, q, e);
        rw = 1'b1; addr = 8'h11; din = 32'h12345678; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_dout", dout, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        access(1'b0, 8'h11, 32'h0, lat, q, e);
        check("abort_lat", lat, 4);
        check("abort_rd11", q, 32'h0);

        // MStrobe held through DONE is taken on the first IDLE edge
        rw = 1'b0; addr = 8'h10; strobe = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) tick();
        check("hold_ready_e4", ready, 1);
        tick();
        check("hold_busy_e5", busy, 0);
        tick();
        check("hold_busy_e6", busy, 1);
        strobe = 1'b0;
        repeat (3) tick();
        check("hold_ready_e9", ready, 0);
        tick();
        check("hold_ready_e10", ready, 1);
        check("hold_dout", dout, 32'hDEADBEEF);
        tick();

`ifdef MEM_ADDR_CHECK_EN
        access(1'b0, 8'hF0, 32'h0, lat, q, e);
        check("oor_rd_lat", lat, 4);
        check("oor_rd_data", q, 32'h0);
        check("oor_rd_err", e, 1);
        access(1'b1, 8'hF0, 32'h77, lat, q, e);
        check("oor_wr_lat", lat, 4);
        check("oor_wr_err", e, 1);
`else
        access(1'b1, 8'hF0, 32'hCAFEF00D, lat, q, e);
        check("hi_wr_err", e, 0);
        access(1'b0, 8'hF0, 32'h0, lat, q, e);
        check("hi_rd_lat", lat, 4);
        check("hi_rd_data", q, 32'hCAFEF00D);
        check("hi_rd_err", e, 0);
`endif

        // WAIT_CYCLES=0 instance behaves as a one-cycle latency
        rw = 1'b1; addr = 8'h40; din = 32'h0BADC0DE; strobe0 = 1'b1;
        tick();
        strobe0 = 1'b0;
        check("w0_wr_ready_e0", ready0, 0);
        check("w0_wr_busy_e0", busy0, 1);
        tick();
        check("w0_wr_ready_e1", ready0, 1);
        check("w0_wr_err", err0, 0);
        tick();
        check("w0_wr_busy_e2", busy0, 0);
        rw = 1'b0; strobe0 = 1'b1;
        tick();
        strobe0 = 1'b0;
        check("w0_rd_ready_e0", ready0, 0);
        tick();
        check("w0_rd_ready_e1", ready0, 1);
        check("w0_rd_data", dout0, 32'h0BADC0DE);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 4, access latency in clocks; values below 1 behave as 1.
REQ-004 SHALL have parameter MEM_DEPTH, default 200, number of populated words (at most 2**ADDR_W).
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port MStrobe  input  1  access request from the cache controller.
REQ-008 SHALL have port MRW  input  1  access type: 1 = write, 0 = read.
REQ-009 SHALL have port MAddr  input  ADDR_W  word address.
REQ-010 SHALL have port MDataIn  input  DATA_W  write data.
REQ-011 SHALL have port MDataOut  output  DATA_W  registered read data.
REQ-012 SHALL have port MReady  output  1  one-cycle completion pulse.
REQ-013 SHALL have port MBusy  output  1  high while an access is in flight.
REQ-014 SHALL have port MErr  output  1  error flag, valid only with MReady.

Function
REQ-015 SHALL implement an FSM with states IDLE, ACCESS and DONE.
REQ-016 In IDLE with MStrobe=1 at a rising edge, SHALL latch MAddr, MRW and MDataIn, load the wait counter with max(WAIT_CYCLES,1), and enter ACCESS.
REQ-017 In ACCESS, SHALL decrement the counter each edge; at the edge where the counter equals 1, SHALL perform the access and enter DONE.
REQ-018 SHALL perform a write by storing the latched data at the latched address; a read SHALL register the array word into MDataOut at that same edge.
REQ-019 SHALL drive MReady=1 only in DONE, for exactly one cycle, then return to IDLE; MReady rises WAIT_CYCLES edges after the accepting edge.
REQ-020 SHALL drive MBusy=1 in ACCESS and DONE, and 0 in IDLE.
REQ-021 SHALL ignore MStrobe in ACCESS and DONE; a request is accepted only in IDLE, with no queuing.
REQ-022 A MStrobe held high through DONE SHALL be accepted as a new request on the first edge in IDLE.
REQ-023 SHALL hold MDataOut until the next read completes; writes SHALL NOT change MDataOut.
REQ-024 SHALL ignore changes on MAddr, MRW and MDataIn after acceptance; only the latched values are used.

Reset
REQ-025 When reset=0, SHALL immediately force the FSM to IDLE, the counter to 0, and MDataOut, MReady, MBusy and MErr to 0.
REQ-026 Reset SHALL NOT clear the memory array; array contents after power-up are undefined.
REQ-027 Reset asserted during ACCESS SHALL abort the access with no array write.

Configuration
REQ-028 With MEM_ADDR_CHECK_EN defined, an access with latched address >= MEM_DEPTH SHALL leave the array unchanged, return MDataOut=0 for a read, and assert MErr=1 together with MReady.
REQ-029 With MEM_ADDR_CHECK_EN defined, SHALL keep the same latency for out-of-range accesses as for in-range accesses.
REQ-030 Without MEM_ADDR_CHECK_EN, SHALL service all 2**ADDR_W addresses normally and tie MErr to 0.

Structure
REQ-031 SHALL place the FSM state enum and the default ADDR_W, DATA_W and WAIT_CYCLES constants in the shared package cache_pkg.
REQ-032 SHALL instantiate one sub-module, mem_wait_ctr: a loadable down-counter with a load input, a load value, a done output and the same asynchronous active-low reset.
REQ-033 SHALL size the array at 2**ADDR_W x DATA_W, with no reset on the array.

Verification
REQ-034 Write: MStrobe=1, MRW=1, MAddr=0x10, MDataIn=0xDEADBEEF at edge 0 -> MBusy=1 from edge 0; MReady=1 only in the cycle after edge 4; MDataOut unchanged.
REQ-035 Read-back: read 0x10 after REQ-034 -> MDataOut=0xDEADBEEF and MReady pulse after edge 4; MErr=0.
REQ-036 Busy ignore: second MStrobe to 0x20 on edges 1-3 of an access -> no extra MReady; write to 0x20 does not occur (verify by a later read).
REQ-037 Reset abort: write 0x11 -> 0x12345678, reset=0 at edge 2 -> outputs are 0 at once; a later read of 0x11 does not return 0x12345678 (preload 0x0 first).
REQ-038 With MEM_ADDR_CHECK_EN: read 0xF0 -> MReady and MErr=1 together after edge 4, MDataOut=0; without the macro, write then read 0xF0 -> data returned, MErr=0.
REQ-039 WAIT_CYCLES=0 build: any access -> MReady after edge 1.
